// File: rtl/vector_register_bank.sv
// Vector register bank: REG_NUM registers of VECTOR_SIZE elements x LEN bits,
// with registered read indices, length-limited and optionally masked
// write-back, a per-register busy scoreboard and a sticky error flag.
// Element 0 is the most significant word of a register, and register 0
// supplies the write mask.

`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b01
`endif

module vector_register_bank #(
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 4,
  parameter int REG_NUM          = 32,
  parameter int REG_INDEX_WIDTH  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy_in,
  input  logic [REG_INDEX_WIDTH-1:0]      rs1,
  input  logic [REG_INDEX_WIDTH-1:0]      rs2,
  output logic [VECTOR_SIZE*LEN-1:0]      rs1_data,
  output logic [VECTOR_SIZE*LEN-1:0]      rs2_data,
  output logic                            rs1_busy,
  output logic                            rs2_busy,
  input  logic                            wr_valid,
  input  logic [REG_INDEX_WIDTH-1:0]      rd,
  input  logic [VECTOR_SIZE*LEN-1:0]      data,
  input  logic [ENTRY_INDEX_SIZE-1:0]     length,
  input  logic                            mask_enable,
  input  logic                            reserve_valid,
  input  logic [REG_INDEX_WIDTH-1:0]      reserve_rd,
  output logic [1:0]                      rf_status,
  output logic                            all_idle,
  output logic                            err
);

  localparam int VW = VECTOR_SIZE * LEN;
  typedef logic [VW-1:0] vec_t;

  // Architectural state and its next-state values
  vec_t                       regs_q [REG_NUM];
  vec_t                       regs_d [REG_NUM];
  logic [REG_NUM-1:0]         busy_q, busy_d;
  logic [REG_INDEX_WIDTH-1:0] rs1_idx_q, rs1_idx_d;
  logic [REG_INDEX_WIDTH-1:0] rs2_idx_q, rs2_idx_d;
  logic [1:0]                 rf_status_q, rf_status_d;
  logic                       err_q, err_d;

  // A register index is usable only if it names an implemented register.
  function automatic logic idx_ok(input logic [REG_INDEX_WIDTH-1:0] idx);
    return int'(idx) < REG_NUM;
  endfunction

  // Requested lengths beyond the vector size are an error.
  function automatic logic len_over(input logic [ENTRY_INDEX_SIZE-1:0] len);
    return int'(len) > VECTOR_SIZE;
  endfunction

  // Number of elements actually written: length clamped to the vector size.
  function automatic int eff_len(input logic [ENTRY_INDEX_SIZE-1:0] len);
    return len_over(len) ? VECTOR_SIZE : int'(len);
  endfunction

  // Merge new data into an old register value element by element. The mask
  // comes from the top VECTOR_SIZE bits of register 0 as it was before the
  // edge, so a masked write to register 0 is governed by its old contents.
  function automatic vec_t merge(input vec_t old_v,
                                 input vec_t new_v,
                                 input vec_t mask_src,
                                 input logic mask_en,
                                 input int   n);
    vec_t r;
    r = old_v;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      if ((i < n) && (!mask_en || mask_src[VW-1-i])) begin
        r[(VECTOR_SIZE-i)*LEN-1 -: LEN] = new_v[(VECTOR_SIZE-i)*LEN-1 -: LEN];
      end
    end
    return r;
  endfunction

  // Next-state logic: index latching, write-back, scoreboard, status and error
  always_comb begin
    regs_d      = regs_q;
    busy_d      = busy_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    rf_status_d = rf_status_q;
    err_d       = err_q;

    if (rdy_in) begin
      rs1_idx_d   = rs1;
      rs2_idx_d   = rs2;
      rf_status_d = `RF_NOP;

      // Write-back clears busy first so a same-edge reservation below wins.
      if (wr_valid) begin
        if (idx_ok(rd)) begin
          regs_d[rd]  = merge(regs_q[rd], data, regs_q[0], mask_enable,
                              eff_len(length));
          busy_d[rd]  = 1'b0;
          rf_status_d = `RF_FINISHED;
          if (len_over(length)) begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end

      if (reserve_valid) begin
        if (idx_ok(reserve_rd)) begin
          busy_d[reserve_rd] = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State registers; synchronous reset overrides any write or reservation
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      busy_q      <= '0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      rf_status_q <= `RF_NOP;
      err_q       <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      rf_status_q <= rf_status_d;
      err_q       <= err_d;
    end
  end

  // Read ports and status are combinational from the registered state
  always_comb begin
    rs1_data  = regs_q[rs1_idx_q];
    rs2_data  = regs_q[rs2_idx_q];
    rs1_busy  = busy_q[rs1_idx_q];
    rs2_busy  = busy_q[rs2_idx_q];
    all_idle  = ~|busy_q;
    rf_status = rf_status_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_vector_register_bank.sv
// Directed bench for vector_register_bank: expectations are queued as each
// step is driven and popped against the DUT outputs after the clock edge.

`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b01
`endif

module tb_vector_register_bank;

  localparam int VW = 256;

  logic            clk = 1'b0;
  logic            rst, rdy_in;
  logic [4:0]      rs1, rs2;
  logic [VW-1:0]   rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy;
  logic            wr_valid;
  logic [4:0]      rd;
  logic [VW-1:0]   data;
  logic [3:0]      length;
  logic            mask_enable;
  logic            reserve_valid;
  logic [4:0]      reserve_rd;
  logic [1:0]      rf_status;
  logic            all_idle, err;

  always #5 clk = ~clk;

  vector_register_bank #(
    .LEN(32), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(4),
    .REG_NUM(32), .REG_INDEX_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .rs1(rs1), .rs2(rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_valid(wr_valid), .rd(rd), .data(data), .length(length),
    .mask_enable(mask_enable),
    .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
    .rf_status(rf_status), .all_idle(all_idle), .err(err)
  );

  localparam int K_RS1D = 0, K_RS2D = 1, K_RS1B = 2, K_RS2B = 3;
  localparam int K_IDLE = 4, K_STAT = 5, K_ERR = 6;

  typedef struct {
    int            kind;
    string         tag;
    logic [VW-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [VW-1:0] v8(input logic [31:0] a, b, c, d,
                                       input logic [31:0] e, f, g, h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  function automatic logic [VW-1:0] fillv(input logic [31:0] w);
    return {8{w}};
  endfunction

  function automatic logic [VW-1:0] observe(input int kind);
    logic [VW-1:0] o;
    o = '0;
    case (kind)
      K_RS1D:  o = rs1_data;
      K_RS2D:  o = rs2_data;
      K_RS1B:  o[0] = rs1_busy;
      K_RS2B:  o[0] = rs2_busy;
      K_IDLE:  o[0] = all_idle;
      K_STAT:  o[1:0] = rf_status;
      K_ERR:   o[0] = err;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic exp_v(input int kind, input string tag, input logic [VW-1:0] v);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic exp_b(input int kind, input string tag, input logic b);
    logic [VW-1:0] v;
    v = '0;
    v[0] = b;
    exp_v(kind, tag, v);
  endtask

  task automatic exp_s(input string tag, input logic [1:0] s);
    logic [VW-1:0] v;
    v = '0;
    v[1:0] = s;
    exp_v(K_STAT, tag, v);
  endtask

  task automatic check_all();
    exp_t          e;
    logic [VW-1:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid      = 1'b0;
    rd            = 5'd0;
    data          = '0;
    length        = 4'd0;
    mask_enable   = 1'b0;
    reserve_valid = 1'b0;
    reserve_rd    = 5'd0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [3:0] l,
                    input logic [VW-1:0] d, input logic m);
    wr_valid    = 1'b1;
    rd          = r;
    length      = l;
    data        = d;
    mask_enable = m;
  endtask

  initial begin
    // Reset with a write pending: the write must be discarded
    rst = 1'b1; rdy_in = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    idle();
    wr(5'd3, 4'd8, fillv(32'hDEADBEEF), 1'b0);
    tick();
    exp_s("rst_status", `RF_NOP);
    exp_b(K_ERR,  "rst_err",  1'b0);
    exp_b(K_IDLE, "rst_idle", 1'b1);
    exp_v(K_RS1D, "rst_rs1_data", '0);
    exp_b(K_RS1B, "rst_rs1_busy", 1'b0);
    tick();
    check_all();

    // Full write to v3 read back the next cycle; status pulses once
    rst = 1'b0;
    idle();
    wr(5'd3, 4'd8, v8(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8), 1'b0);
    rs1 = 5'd3;
    exp_v(K_RS1D, "wr3_data", v8(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8));
    exp_s("wr3_status_fin", `RF_FINISHED);
    tick();
    check_all();
    idle();
    exp_s("wr3_status_nop", `RF_NOP);
    exp_v(K_RS1D, "wr3_data_hold", v8(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8));
    tick();
    check_all();

    // Partial length write keeps the tail elements
    wr(5'd5, 4'd8, fillv(32'hFFFFFFFF), 1'b0);
    tick();
    wr(5'd5, 4'd3, '0, 1'b0);
    rs2 = 5'd5;
    exp_v(K_RS2D, "len3_data", v8(32'h0, 32'h0, 32'h0, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF));
    exp_b(K_ERR, "len3_err", 1'b0);
    tick();
    check_all();

    // Zero length changes nothing but still completes
    wr(5'd5, 4'd0, fillv(32'h12345678), 1'b0);
    exp_v(K_RS2D, "len0_data", v8(32'h0, 32'h0, 32'h0, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF));
    exp_s("len0_status", `RF_FINISHED);
    tick();
    check_all();

    // Masked write: v0 mask 10100000 selects elements 0 and 2 of v7
    wr(5'd7, 4'd8, fillv(32'h22222222), 1'b0);
    tick();
    wr(5'd0, 4'd1, v8(32'hA0000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0), 1'b0);
    tick();
    wr(5'd7, 4'd8, fillv(32'h11111111), 1'b1);
    rs1 = 5'd7;
    exp_v(K_RS1D, "mask_v7", v8(32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222,
                                32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222));
    tick();
    check_all();

    // Masked write to v0 uses its own pre-write mask
    wr(5'd0, 4'd8, fillv(32'hFFFFFFFF), 1'b1);
    rs1 = 5'd0;
    exp_v(K_RS1D, "mask_v0_self", v8(32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0,
                                     32'h0, 32'h0, 32'h0, 32'h0));
    tick();
    check_all();

    // Scoreboard: reserve, same-edge reserve+write, then write alone
    idle();
    reserve_valid = 1'b1; reserve_rd = 5'd9; rs1 = 5'd9;
    exp_b(K_RS1B, "resv9_busy", 1'b1);
    exp_b(K_IDLE, "resv9_idle", 1'b0);
    tick();
    check_all();
    wr(5'd9, 4'd8, fillv(32'h55555555), 1'b0);
    exp_b(K_RS1B, "resv_wr9_busy", 1'b1);
    exp_v(K_RS1D, "resv_wr9_data", fillv(32'h55555555));
    exp_s("resv_wr9_status", `RF_FINISHED);
    tick();
    check_all();
    idle();
    wr(5'd9, 4'd8, fillv(32'h66666666), 1'b0);
    exp_b(K_RS1B, "wr9_busy", 1'b0);
    exp_b(K_IDLE, "wr9_idle", 1'b1);
    exp_b(K_ERR,  "wr9_err",  1'b0);
    tick();
    check_all();

    // Reserve and write to different registers on one edge
    reserve_valid = 1'b1; reserve_rd = 5'd10; rs2 = 5'd10;
    exp_b(K_RS2B, "resv10_busy", 1'b1);
    exp_b(K_RS1B, "wr9b_busy",   1'b0);
    exp_b(K_IDLE, "resv10_idle", 1'b0);
    tick();
    check_all();
    idle();
    wr(5'd10, 4'd8, fillv(32'h77777777), 1'b0);
    exp_b(K_RS2B, "wr10_busy", 1'b0);
    exp_b(K_IDLE, "wr10_idle", 1'b1);
    exp_v(K_RS2D, "wr10_data", fillv(32'h77777777));
    tick();
    check_all();

    // Over-length write clamps to 8 elements and sets the sticky error
    wr(5'd11, 4'd12, fillv(32'h33333333), 1'b0);
    rs1 = 5'd11;
    exp_v(K_RS1D, "len12_data", fillv(32'h33333333));
    exp_b(K_ERR,  "len12_err",  1'b1);
    exp_s("len12_status", `RF_FINISHED);
    tick();
    check_all();

    // Stall: everything frozen, write and reservation ignored
    rdy_in = 1'b0;
    wr(5'd11, 4'd8, fillv(32'h44444444), 1'b0);
    reserve_valid = 1'b1; reserve_rd = 5'd12; rs1 = 5'd3;
    exp_v(K_RS1D, "stall_data",   fillv(32'h33333333));
    exp_s("stall_status", `RF_FINISHED);
    exp_b(K_ERR,  "stall_err",    1'b1);
    exp_b(K_IDLE, "stall_idle",   1'b1);
    tick();
    check_all();
    rdy_in = 1'b1;
    idle();
    rs1 = 5'd11;
    exp_s("post_stall_status", `RF_NOP);
    exp_b(K_ERR,  "err_sticky",      1'b1);
    exp_v(K_RS1D, "post_stall_data", fillv(32'h33333333));
    exp_b(K_IDLE, "post_stall_idle", 1'b1);
    tick();
    check_all();

    // Reset wins over a simultaneous write and reservation, even while stalled
    rst = 1'b1; rdy_in = 1'b0;
    wr(5'd3, 4'd8, fillv(32'h99999999), 1'b0);
    reserve_valid = 1'b1; reserve_rd = 5'd4; rs1 = 5'd3;
    exp_v(K_RS1D, "rst2_data", '0);
    exp_b(K_ERR,  "rst2_err",  1'b0);
    exp_s("rst2_status", `RF_NOP);
    exp_b(K_IDLE, "rst2_idle", 1'b1);
    tick();
    check_all();
    rst = 1'b0; rdy_in = 1'b1;
    idle();
    rs1 = 5'd3; rs2 = 5'd11;
    exp_v(K_RS1D, "rst2_v3",  '0);
    exp_v(K_RS2D, "rst2_v11", '0);
    tick();
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
